// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if : operand/result bundle for the alu block.
//
// Signals
//   a, b      operands (A: dividend / shift source / unary source, B: divisor /
//             shift amount)
//   op        4-bit operation select
//   in_valid  operands/op valid this cycle
//   result    registered 64-bit result
//   out_valid in_valid delayed by one clock
//   flags     {div_by_zero, overflow, negative, zero}; present only when the
//             ALU_FLAGS_EN macro is defined
//
// Modports
//   master : drives operands, observes result (the datapath / a testbench)
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         op;
  logic               in_valid;
  logic [2*WIDTH-1:0] result;
  logic               out_valid;
`ifdef ALU_FLAGS_EN
  logic [3:0]         flags;

  modport master (output a, b, op, in_valid, input result, out_valid, flags);
  modport slave  (input a, b, op, in_valid, output result, out_valid, flags);
`else
  modport master (output a, b, op, in_valid, input result, out_valid);
  modport slave  (input a, b, op, in_valid, output result, out_valid);
`endif
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu : 32-bit two-operand ALU with a single output register (latency 1).
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears result, out_valid (and flags)
//   bus    alu_if.slave : a, b, op, in_valid in; result, out_valid out
//
// Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL (signed, 64-bit product),
//          5 DIV (signed; quotient low word, remainder high word), 6 SHR,
//          7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT, 13-15 -> 0.
// 32-bit ops are zero-extended into result[63:32].
//
// Optional feature macro: ALU_FLAGS_EN adds bus.flags[3:0]
//   {div_by_zero, overflow, negative, zero}, registered with result.
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  localparam int RW  = 2 * WIDTH;
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]        a;
  logic [WIDTH-1:0]        b;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SHW-1:0]          sh_amt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] neg_a;
  logic [RW-1:0]    prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [RW-1:0]    rot_r;
  logic [RW-1:0]    rot_l;

  logic [RW-1:0] result_d, result_q;
  logic          valid_d, valid_q;

  assign a      = bus.a;
  assign b      = bus.b;
  assign a_s    = bus.a;
  assign b_s    = bus.b;
  assign sh_amt = bus.b[SHW-1:0];

  assign sum   = a + b;
  assign diff  = a - b;
  assign neg_a = '0 - a;

  // Sign-extending both operands to 64 bits makes the low 64 bits of an
  // unsigned multiply equal to the signed two's-complement product.
  assign prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

  // Rotates are shifts of the operand concatenated with itself.
  assign rot_r = {a, a} >> sh_amt;
  assign rot_l = {a, a} << sh_amt;

  // Divide-by-zero and the single overflowing case are resolved explicitly so
  // the generic divider path never sees them.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b == '0) begin
      quot = '1;
      rem  = a;
    end else if (a == MIN_INT && b == '1) begin
      quot = MIN_INT;
      rem  = '0;
    end else begin
      quot = a_s / b_s;
      rem  = a_s % b_s;
    end
  end

  always_comb begin
    result_d = '0;
    case (bus.op)
      OP_AND:  result_d = {{WIDTH{1'b0}}, a & b};
      OP_OR:   result_d = {{WIDTH{1'b0}}, a | b};
      OP_ADD:  result_d = {{WIDTH{1'b0}}, sum};
      OP_SUB:  result_d = {{WIDTH{1'b0}}, diff};
      OP_MUL:  result_d = prod;
      OP_DIV:  result_d = {rem, quot};
      OP_SHR:  result_d = {{WIDTH{1'b0}}, a >> sh_amt};
      OP_SHRA: result_d = {{WIDTH{1'b0}}, a_s >>> sh_amt};
      OP_SHL:  result_d = {{WIDTH{1'b0}}, a << sh_amt};
      OP_ROR:  result_d = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
      OP_ROL:  result_d = {{WIDTH{1'b0}}, rot_l[RW-1:WIDTH]};
      OP_NEG:  result_d = {{WIDTH{1'b0}}, neg_a};
      OP_NOT:  result_d = {{WIDTH{1'b0}}, ~a};
      default: result_d = '0;
    endcase
  end

  assign valid_d = bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = valid_q;

`ifdef ALU_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  logic       ovf;

  always_comb begin
    ovf = 1'b0;
    case (bus.op)
      OP_ADD: ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      OP_SUB: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      OP_NEG: ovf = (a == MIN_INT);
      // The product fits in 32 bits only if bits [63:31] are all copies of
      // the sign bit.
      OP_MUL: ovf = !((&prod[RW-1:WIDTH-1]) || !(|prod[RW-1:WIDTH-1]));
      default: ovf = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = '0;
    if (bus.op == OP_MUL) begin
      flags_d[0] = (result_d == '0);
      flags_d[1] = result_d[RW-1];
    end else begin
      flags_d[0] = (result_d[WIDTH-1:0] == '0);
      flags_d[1] = result_d[WIDTH-1];
    end
    flags_d[2] = ovf;
    flags_d[3] = (bus.op == OP_DIV) && (b == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.flags = flags_q;
`endif

endmodule

// File: tb/tb_alu.sv
`timescale 1ns/1ps
module tb_alu;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [63:0] exp;
  } vec_t;

  // Apply one set of inputs, let one rising edge pass, return 1 ns later so
  // the registered outputs can be sampled away from the edge.
  task automatic drive(input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic [3:0] op_i, input logic v_i);
    bus.a        = a_i;
    bus.b        = b_i;
    bus.op       = op_i;
    bus.in_valid = v_i;
    @(posedge clk);
    #1;
    $display("txn op=%0d a=%h b=%h in_valid=%b reset=%b -> result=%h out_valid=%b",
             op_i, a_i, b_i, v_i, reset, bus.result, bus.out_valid);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(32'd5, 32'd3, 4'd1, 1'b1);
      checks++;
      if (bus.result !== 64'd0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: result=%h out_valid=%b, expected 0/0",
                 i, bus.result, bus.out_valid);
      end
`ifdef ALU_FLAGS_EN
      checks++;
      if (bus.flags !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: flags=%b, expected 0000", i, bus.flags);
      end
`endif
    end
    reset = 1'b0;
    // Result is computed even without in_valid; out_valid stays low.
    drive(32'd5, 32'd3, 4'd1, 1'b0);
    checks++;
    if (bus.result !== 64'd7 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: result=%h out_valid=%b, expected 7/0",
               bus.result, bus.out_valid);
    end
    drive(32'd5, 32'd3, 4'd1, 1'b1);
    checks++;
    if (bus.result !== 64'd7 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first: result=%h out_valid=%b, expected 7/1",
               bus.result, bus.out_valid);
    end
  endtask

  task automatic test_logic_arith();
    vec_t v [5];
    v = '{
      '{32'd1,         32'd0,  4'd0, 64'd0},
      '{32'd1,         32'd0,  4'd1, 64'd1},
      '{32'd12,        32'd28, 4'd2, 64'd40},
      '{32'd32,        32'd20, 4'd3, 64'd12},
      '{32'h7FFFFFFF,  32'd1,  4'd2, 64'h0000_0000_8000_0000}
    };
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b1);
      checks++;
      if (bus.result !== v[i].exp || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL logic_arith[%0d]: result=%h out_valid=%b, expected %h/1",
                 i, bus.result, bus.out_valid, v[i].exp);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v [5];
    v = '{
      '{32'd3,        32'd4,        4'd4, 64'h0000_0000_0000_000C},
      '{32'hFFFFFFFD, 32'd4,        4'd4, 64'hFFFF_FFFF_FFFF_FFF4},
      '{32'd3,        32'hFFFFFFFC, 4'd4, 64'hFFFF_FFFF_FFFF_FFF4},
      '{32'hFFFFFFFD, 32'hFFFFFFFC, 4'd4, 64'd12},
      '{32'h00010000, 32'h00010000, 4'd4, 64'h0000_0001_0000_0000}
    };
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b1);
      checks++;
      if (bus.result !== v[i].exp) begin
        errors++;
        $display("FAIL mul[%0d]: result=%h, expected %h", i, bus.result, v[i].exp);
      end
    end
  endtask

  task automatic test_div();
    vec_t v [5];
    v = '{
      '{32'd24,       32'd12,       4'd5, 64'h0000_0000_0000_0002},
      '{32'hFFFFFFF9, 32'd2,        4'd5, 64'hFFFF_FFFF_FFFF_FFFD},
      '{32'd5,        32'd0,        4'd5, 64'h0000_0005_FFFF_FFFF},
      '{32'h80000000, 32'hFFFFFFFF, 4'd5, 64'h0000_0000_8000_0000},
      '{32'd7,        32'hFFFFFFFE, 4'd5, 64'h0000_0001_FFFF_FFFD}
    };
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b1);
      checks++;
      if (bus.result !== v[i].exp) begin
        errors++;
        $display("FAIL div[%0d]: result=%h, expected %h", i, bus.result, v[i].exp);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v [11];
    v = '{
      '{32'd4,        32'd2,  4'd6,  64'd1},
      '{32'd8,        32'd2,  4'd7,  64'd2},
      '{32'h80000000, 32'd4,  4'd7,  64'h0000_0000_F800_0000},
      '{32'd4,        32'd1,  4'd8,  64'd8},
      '{32'hFFFFFFFC, 32'd1,  4'd9,  64'h0000_0000_7FFF_FFFE},
      '{32'd4,        32'd1,  4'd10, 64'd8},
      '{32'd1,        32'd33, 4'd8,  64'd2},
      '{32'hDEADBEEF, 32'd32, 4'd6,  64'h0000_0000_DEAD_BEEF},
      '{32'h80000000, 32'd31, 4'd6,  64'd1},
      '{32'h80000001, 32'd4,  4'd10, 64'h0000_0000_0000_0018},
      '{32'h12345678, 32'd8,  4'd9,  64'h0000_0000_7812_3456}
    };
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b1);
      checks++;
      if (bus.result !== v[i].exp) begin
        errors++;
        $display("FAIL shift[%0d]: result=%h, expected %h", i, bus.result, v[i].exp);
      end
    end
  endtask

  task automatic test_unary();
    vec_t v [6];
    v = '{
      '{32'hFFFFFFF8, 32'd0,        4'd11, 64'd8},
      '{32'h80000000, 32'd0,        4'd11, 64'h0000_0000_8000_0000},
      '{32'd4,        32'd0,        4'd12, 64'h0000_0000_FFFF_FFFB},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd13, 64'd0},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd14, 64'd0},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 64'd0}
    };
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b1);
      checks++;
      if (bus.result !== v[i].exp) begin
        errors++;
        $display("FAIL unary[%0d]: result=%h, expected %h", i, bus.result, v[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [5];
    logic [4:0] vld;
    v = '{
      '{32'd100,      32'd23,       4'd2, 64'd123},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'd0, 64'h0000_0000_00F0_00F0},
      '{32'd9,        32'hFFFFFFFF, 4'd4, 64'hFFFF_FFFF_FFFF_FFF7},
      '{32'd10,       32'd3,        4'd5, 64'h0000_0001_0000_0003},
      '{32'd0,        32'd1,        4'd3, 64'h0000_0000_FFFF_FFFF}
    };
    vld = 5'b01101;
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, vld[i]);
      checks++;
      if (bus.result !== v[i].exp || bus.out_valid !== vld[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: result=%h out_valid=%b, expected %h/%b",
                 i, bus.result, bus.out_valid, v[i].exp, vld[i]);
      end
    end
    // Reset mid-stream clears the output on that very edge.
    reset = 1'b1;
    drive(32'd1, 32'd2, 4'd2, 1'b1);
    checks++;
    if (bus.result !== 64'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: result=%h out_valid=%b, expected 0/0",
               bus.result, bus.out_valid);
    end
    reset = 1'b0;
    drive(32'd1, 32'd2, 4'd2, 1'b1);
    checks++;
    if (bus.result !== 64'd3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_midstream_reset: result=%h out_valid=%b, expected 3/1",
               bus.result, bus.out_valid);
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [3:0]  exp;
    } fvec_t;
    fvec_t v [7];
    v = '{
      '{32'hFFFFFFFF, 32'd0,        4'd12, 4'b0001},
      '{32'h7FFFFFFF, 32'd1,        4'd2,  4'b0110},
      '{32'd5,        32'd0,        4'd5,  4'b1010},
      '{32'h00010000, 32'h00010000, 4'd4,  4'b0100},
      '{32'hFFFFFFFD, 32'd4,        4'd4,  4'b0010},
      '{32'h80000000, 32'd0,        4'd11, 4'b0110},
      '{32'h80000000, 32'd1,        4'd3,  4'b0100}
    };
    foreach (v[i]) begin
      drive(v[i].a, v[i].b, v[i].op, 1'b1);
      checks++;
      if (bus.flags !== v[i].exp) begin
        errors++;
        $display("FAIL flags[%0d]: flags=%b, expected %b", i, bus.flags, v[i].exp);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.a        = '0;
    bus.b        = '0;
    bus.op       = '0;
    bus.in_valid = 1'b0;
    #1;
    test_reset();
    test_logic_arith();
    test_mul();
    test_div();
    test_shift();
    test_unary();
    test_back_to_back();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
